xyz_drive_seq: RTL and testbench

//   Upstream feeder for the xyz stage: it generates xyz's primary inputs signal_b[2:0] and signal_e3.
//   It accepts command words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
//   It presents each word on signal_b/signal_e3 for a programmable number of cycles, then returns
//   the outputs to the idle value.

---
 rtl/xyz_drive_seq.sv | 156 +++++++++++++++
 tb/tb_xyz_drive_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/xyz_drive_seq.sv
// Upstream feeder for the xyz stage: buffers command words in a small FIFO and
// drives each word on signal_b/signal_e3 for in_hold+1 cycles, idling at zero otherwise.
module xyz_drive_seq #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_b,
    input  logic                       in_e3,
    input  logic [HOLD_W-1:0]          in_hold,
    output logic [2:0]                 signal_b,
    output logic                       signal_e3,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 + HOLD_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state_q;
    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [2:0]          sig_b_q;
    logic                sig_e3_q;
    logic                busy_q;

    logic                push_s;
    logic                pop_s;
    logic [EW-1:0]       head_s;
    logic [2:0]          head_b_s;
    logic                head_e3_s;
    logic [HOLD_W-1:0]   head_hold_s;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign push_s      = in_valid & in_ready;
    assign head_s      = mem_q[rd_ptr_q];
    assign head_b_s    = head_s[EW-1 -: 3];
    assign head_e3_s   = head_s[HOLD_W];
    assign head_hold_s = head_s[HOLD_W-1:0];

    assign signal_b  = sig_b_q;
    assign signal_e3 = sig_e3_q;
    assign busy      = busy_q;
    assign count     = count_q;

    // Pop decision and FIFO pointer/occupancy next-state.
    always_comb begin
        pop_s    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A pop happens whenever the FSM is free to take the head word.
        if ((count_q != CW'(0)) && ((state_q == ST_IDLE) || (hold_q == HOLD_W'(0)))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {in_b, in_e3, in_hold};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Output sequencer: load, hold and release words with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= {HOLD_W{1'b0}};
            sig_b_q  <= 3'b000;
            sig_e3_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_q  <= ST_HOLD;
                        hold_q   <= head_hold_s;
                        sig_b_q  <= head_b_s;
                        sig_e3_q <= head_e3_s;
                        busy_q   <= 1'b1;
                    end else begin
                        sig_b_q  <= 3'b000;
                        sig_e3_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (hold_q != HOLD_W'(0)) begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end else if (pop_s) begin
                        // Next word follows with no idle bubble.
                        hold_q   <= head_hold_s;
                        sig_b_q  <= head_b_s;
                        sig_e3_q <= head_e3_s;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= ST_IDLE;
                        sig_b_q  <= 3'b000;
                        sig_e3_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    hold_q   <= {HOLD_W{1'b0}};
                    sig_b_q  <= 3'b000;
                    sig_e3_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xyz_drive_seq.sv
// Scoreboard bench for xyz_drive_seq: accepted words are queued with their push edge
// and compared against the outputs cycle by cycle.
module tb_xyz_drive_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_b;
    logic       in_e3;
    logic [3:0] in_hold;
    logic [2:0] signal_b;
    logic       signal_e3;
    logic       busy;
    logic [2:0] count;

    typedef struct {
        logic [2:0] b;
        logic       e3;
        logic [3:0] h;
        int         n;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         rem = 0;
    logic [2:0] cur_b;
    logic       cur_e3;
    int         checks = 0;
    int         errors = 0;

    xyz_drive_seq #(.DEPTH(4), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .in_e3     (in_e3),
        .in_hold   (in_hold),
        .signal_b  (signal_b),
        .signal_e3 (signal_e3),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Compare outputs after an edge against the scoreboard.
    task automatic monitor();
        exp_t e;
        if (rem > 0) begin
            chk("hold_b", 32'(signal_b), 32'(cur_b));
            chk("hold_e3", 32'(signal_e3), 32'(cur_e3));
            chk("hold_busy", 32'(busy), 32'd1);
            rem--;
        end else if (sb.size() > 0 && sb[0].n < cyc) begin
            e = sb.pop_front();
            chk("word_b", 32'(signal_b), 32'(e.b));
            chk("word_e3", 32'(signal_e3), 32'(e.e3));
            chk("word_busy", 32'(busy), 32'd1);
            cur_b  = e.b;
            cur_e3 = e.e3;
            rem    = int'(e.h);
        end else begin
            chk("idle_b", 32'(signal_b), 32'd0);
            chk("idle_e3", 32'(signal_e3), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        chk("count", 32'(count), 32'(sb.size()));
        chk("in_ready", 32'(in_ready), (sb.size() != 4) ? 32'd1 : 32'd0);
    endtask

    task automatic step(output logic acc);
        acc = in_valid && in_ready;
        @(posedge clk);
        cyc++;
        if (acc) sb.push_back('{b: in_b, e3: in_e3, h: in_hold, n: cyc});
        #1;
        monitor();
    endtask

    task automatic idle(input int n);
        logic acc;
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step(acc);
    endtask

    // Present a word and keep it valid until accepted; returns cycles stalled.
    task automatic drive(input logic [2:0] b, input logic e3, input logic [3:0] h, output int stalls);
        logic acc;
        acc      = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        in_b     = b;
        in_e3    = e3;
        in_hold  = h;
        for (int k = 0; k < 100; k++) begin
            step(acc);
            if (acc) break;
            stalls++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int st;
        int max_st;
        logic acc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_b     = 3'b000;
        in_e3    = 1'b0;
        in_hold  = 4'd0;
        #12;
        chk("rst_b", 32'(signal_b), 32'd0);
        chk("rst_e3", 32'(signal_e3), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle after reset
        idle(6);

        // 2: single word, 3 cycles
        drive(3'b101, 1'b1, 4'd2, st);
        idle(8);

        // 3: back-to-back with no bubble
        drive(3'b001, 1'b0, 4'd0, st);
        drive(3'b110, 1'b1, 4'd1, st);
        idle(6);

        // 4: fill the FIFO behind a long word; the last push must stall
        max_st = 0;
        drive(3'b111, 1'b1, 4'd15, st);
        for (int i = 0; i < 5; i++) begin
            drive(3'(i), i[0], 4'd0, st);
            if (st > max_st) max_st = st;
        end
        chk("full_stalled", (max_st > 0) ? 32'd1 : 32'd0, 32'd1);
        idle(25);

        // 5: streaming wrap-around
        for (int i = 0; i < 10; i++) drive(3'(i + 3), i[1], 4'd0, st);
        idle(15);

        // random traffic
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step(acc);
            end else begin
                drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), st);
            end
        end
        idle(60);

        // 6: asynchronous reset in the middle of a held word with two queued
        drive(3'b011, 1'b1, 4'd5, st);
        drive(3'b100, 1'b0, 4'd1, st);
        drive(3'b010, 1'b1, 4'd1, st);
        in_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_b", 32'(signal_b), 32'd0);
        chk("async_e3", 32'(signal_e3), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_ready", 32'(in_ready), 32'd1);
        sb.delete();
        rem = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
